// File: rtl/word_bus_pkg.sv
// Shared types and widths for the split-word bus writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package word_bus_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_t;

endpackage

// File: rtl/word_hold_slot.sv
// One-entry holding slot that parks a word accepted while the writer is busy.
// Latency: load visible on dataOut/full the cycle after the load edge.
// Backpressure: owner must not load while full; unload simply empties it.
module word_hold_slot
  import word_bus_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic [WORD_W-1:0] dataIn,
  output logic [WORD_W-1:0] dataOut,
  output logic              full
);

  // Capture on load, release on unload; reset drops any parked word.
  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= 1'b0;
      dataOut <= '0;
    end else if (load) begin
      full    <= 1'b1;
      dataOut <= dataIn;
    end else if (unload) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/word_bus_writer.sv
// Sends a 16-bit word as two strobed byte transfers (setHigh/setLow) on the 8-bit bus.
// Latency: first byte the cycle after accept; 3 cycles/word (2 with WORD_BUS_WRITER_SKID_EN).
// Backpressure: busReady low holds the current byte and strobe; wordReady low while busy or slot full.
module word_bus_writer
  import word_bus_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] wordIn,
  input  logic              wordValid,
  output logic              wordReady,
  input  logic              busReady,
  output logic [BYTE_W-1:0] halfValueOut,
  output logic              setHighOut,
  output logic              setLowOut,
  output logic              busy,
  output logic              wordDone
);

  state_t            state;
  state_t            next_state;
  logic [WORD_W-1:0] word_q;
  logic              load_word;
  logic              done_d;
  logic              done_q;
  logic              live_q;   // low during and one cycle past reset, gating wordReady
  logic              accept;
  logic              first_phase;
  logic              second_phase;

`ifdef WORD_BUS_WRITER_SKID_EN
  logic              slot_full;
  logic [WORD_W-1:0] slot_dat;
  logic              slot_load;
  logic              unload_slot;

  assign wordReady = live_q && !slot_full;
  // A word that cannot go straight into word_q is parked in the slot.
  assign slot_load = accept && !load_word;

  word_hold_slot u_slot (
    .clock   (clock),
    .reset   (reset),
    .load    (slot_load),
    .unload  (unload_slot),
    .dataIn  (wordIn),
    .dataOut (slot_dat),
    .full    (slot_full)
  );
`else
  assign wordReady = live_q && (state == IDLE);
`endif

  assign accept = wordValid && wordReady;

  // Next-state: walk the two halves, stalling on busReady.
  always_comb begin
    next_state = state;
    load_word  = 1'b0;
    done_d     = 1'b0;
`ifdef WORD_BUS_WRITER_SKID_EN
    unload_slot = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SEND_FIRST;
          load_word  = 1'b1;
        end
      end
      SEND_FIRST: begin
        if (busReady) next_state = SEND_SECOND;
      end
      SEND_SECOND: begin
        if (busReady) begin
          done_d     = 1'b1;
          next_state = IDLE;
`ifdef WORD_BUS_WRITER_SKID_EN
          // Chain straight into the next word with no IDLE bubble.
          if (slot_full) begin
            next_state  = SEND_FIRST;
            unload_slot = 1'b1;
          end else if (accept) begin
            next_state = SEND_FIRST;
            load_word  = 1'b1;
          end
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, done pulse and ready gate registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= done_d;
      live_q <= 1'b1;
    end
  end

  // Word register: only written at an accept (or slot hand-off), so later wordIn changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
    end else if (load_word) begin
      word_q <= wordIn;
`ifdef WORD_BUS_WRITER_SKID_EN
    end else if (unload_slot) begin
      word_q <= slot_dat;
`endif
    end
  end

  // Outputs decode registered state and word only; strobes are mutually exclusive by state.
  assign first_phase  = (state == SEND_FIRST);
  assign second_phase = (state == SEND_SECOND);
  assign setHighOut   = HIGH_FIRST ? first_phase : second_phase;
  assign setLowOut    = HIGH_FIRST ? second_phase : first_phase;
  assign halfValueOut = setHighOut ? word_q[WORD_W-1:BYTE_W] :
                        setLowOut  ? word_q[BYTE_W-1:0]      : '0;
  assign busy         = (state != IDLE);
  assign wordDone     = done_q;

endmodule

// File: tb/tb_word_bus_writer.sv
// Directed bench for word_bus_writer: two instances (high-first and low-first) share stimulus.
// Latency: n/a.
// Backpressure: busReady driven from directed tables.
module tb_word_bus_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] wordIn;
  logic        wordValid;
  logic        busReady;

  logic        wordReady_hf, setHigh_hf, setLow_hf, busy_hf, wordDone_hf;
  logic [7:0]  half_hf;
  logic        wordReady_lf, setHigh_lf, setLow_lf, busy_lf, wordDone_lf;
  logic [7:0]  half_lf;

  logic [15:0] rx_hf;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  word_bus_writer #(.HIGH_FIRST(1'b1)) u_hf (
    .clock        (clock),
    .reset        (reset),
    .wordIn       (wordIn),
    .wordValid    (wordValid),
    .wordReady    (wordReady_hf),
    .busReady     (busReady),
    .halfValueOut (half_hf),
    .setHighOut   (setHigh_hf),
    .setLowOut    (setLow_hf),
    .busy         (busy_hf),
    .wordDone     (wordDone_hf)
  );

  word_bus_writer #(.HIGH_FIRST(1'b0)) u_lf (
    .clock        (clock),
    .reset        (reset),
    .wordIn       (wordIn),
    .wordValid    (wordValid),
    .wordReady    (wordReady_lf),
    .busReady     (busReady),
    .halfValueOut (half_lf),
    .setHighOut   (setHigh_lf),
    .setLowOut    (setLow_lf),
    .busy         (busy_lf),
    .wordDone     (wordDone_lf)
  );

  // Paired two-phase receiver: loads each half when its strobe is taken.
  always @(posedge clock) begin
    if (busReady && setHigh_hf) rx_hf[15:8] <= half_hf;
    if (busReady && setLow_hf)  rx_hf[7:0]  <= half_hf;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // {busy, wordReady, wordDone, setHigh, setLow, half}
  function automatic logic [12:0] ev(input logic b, input logic r, input logic d,
                                     input logic h, input logic l, input logic [7:0] v);
    return {b, r, d, h, l, v};
  endfunction

  function automatic logic [12:0] pk_hf();
    return {busy_hf, wordReady_hf, wordDone_hf, setHigh_hf, setLow_hf, half_hf};
  endfunction

  function automatic logic [12:0] pk_lf();
    return {busy_lf, wordReady_lf, wordDone_lf, setHigh_lf, setLow_lf, half_lf};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] b2b_exp [6];
    int          b2b_len;
    int          b2b_gap;
    int          acc_cycle;
    logic        acc;

`ifdef WORD_BUS_WRITER_SKID_EN
    b2b_len    = 5;
    b2b_gap    = 1;
    b2b_exp[0] = ev(1, 1, 0, 1, 0, 8'h00);
    b2b_exp[1] = ev(1, 0, 0, 0, 1, 8'h01);
    b2b_exp[2] = ev(1, 1, 1, 1, 0, 8'hFF);
    b2b_exp[3] = ev(1, 1, 0, 0, 1, 8'hFF);
    b2b_exp[4] = ev(0, 1, 1, 0, 0, 8'h00);
    b2b_exp[5] = ev(0, 1, 0, 0, 0, 8'h00);
`else
    b2b_len    = 6;
    b2b_gap    = 3;
    b2b_exp[0] = ev(1, 0, 0, 1, 0, 8'h00);
    b2b_exp[1] = ev(1, 0, 0, 0, 1, 8'h01);
    b2b_exp[2] = ev(0, 1, 1, 0, 0, 8'h00);
    b2b_exp[3] = ev(1, 0, 0, 1, 0, 8'hFF);
    b2b_exp[4] = ev(1, 0, 0, 0, 1, 8'hFF);
    b2b_exp[5] = ev(0, 1, 1, 0, 0, 8'h00);
`endif

    reset = 1'b1; wordValid = 1'b0; wordIn = 16'h0000; busReady = 1'b0;
    step(); step();
    chk("rst_hf", 32'(pk_hf()), 32'(ev(0, 0, 0, 0, 0, 8'h00)));
    chk("rst_lf", 32'(pk_lf()), 32'(ev(0, 0, 0, 0, 0, 8'h00)));
    reset = 1'b0;
    step();
    chk("post_rst", 32'(pk_hf()), 32'(ev(0, 1, 0, 0, 0, 8'h00)));

    // Single word, busReady tied high.
    wordIn = 16'hA55A; wordValid = 1'b1; busReady = 1'b1;
    step();
    wordValid = 1'b0; wordIn = 16'h0000;
    chk("a55a_n1", 32'(pk_hf()), 32'(ev(1, 0, 0, 1, 0, 8'hA5)));
    step();
    chk("a55a_n2", 32'(pk_hf()), 32'(ev(1, 0, 0, 0, 1, 8'h5A)));
    step();
    chk("a55a_n3", 32'(pk_hf()), 32'(ev(0, 1, 1, 0, 0, 8'h00)));
    chk("a55a_rx", 32'(rx_hf), 32'h0000A55A);
    step();
    chk("a55a_n4", 32'(pk_hf()), 32'(ev(0, 1, 0, 0, 0, 8'h00)));

    // Back-pressure: two stall cycles on each byte.
    wordIn = 16'h1234; wordValid = 1'b1; busReady = 1'b0;
    step();
    wordValid = 1'b0; wordIn = 16'hDEAD;
    for (int i = 0; i < 6; i++) begin
      busReady = (i == 2 || i == 5);
      chk($sformatf("bp_%0d", i), 32'(pk_hf()),
          32'(ev(1, 0, 0, i < 3, i >= 3, (i < 3) ? 8'h12 : 8'h34)));
      step();
    end
    chk("bp_done", 32'(pk_hf()), 32'(ev(0, 1, 1, 0, 0, 8'h00)));

    // Low-first ordering.
    wordIn = 16'hBEEF; wordValid = 1'b1; busReady = 1'b1;
    step();
    wordValid = 1'b0;
    chk("beef_1", 32'(pk_lf()), 32'(ev(1, 0, 0, 0, 1, 8'hEF)));
    step();
    chk("beef_2", 32'(pk_lf()), 32'(ev(1, 0, 0, 1, 0, 8'hBE)));
    step();
    chk("beef_3", 32'(pk_lf()), 32'(ev(0, 1, 1, 0, 0, 8'h00)));

    // Reset while sending the second byte; wordValid held through reset is not taken.
    wordIn = 16'h1234; wordValid = 1'b1; busReady = 1'b1;
    step();
    wordValid = 1'b0;
    step();
    chk("rs_second", 32'(pk_hf()), 32'(ev(1, 0, 0, 0, 1, 8'h34)));
    reset = 1'b1; wordValid = 1'b1; wordIn = 16'h5555;
    step();
    chk("rs_in", 32'(pk_hf()), 32'(ev(0, 0, 0, 0, 0, 8'h00)));
    reset = 1'b0;
    step();
    wordValid = 1'b0;
    chk("rs_rel", 32'(pk_hf()), 32'(ev(0, 1, 0, 0, 0, 8'h00)));
    step();
    chk("rs_quiet", 32'(pk_hf()), 32'(ev(0, 1, 0, 0, 0, 8'h00)));

    // Back-to-back words 0001 then FFFF with busReady high.
    wordIn = 16'h0001; wordValid = 1'b1; busReady = 1'b1;
    step();
    wordIn = 16'hFFFF;
    acc_cycle = -1;
    for (int c = 0; c < b2b_len; c++) begin
      chk($sformatf("b2b_%0d", c + 1), 32'(pk_hf()), 32'(b2b_exp[c]));
      acc = wordValid && wordReady_hf;
      if (acc && acc_cycle < 0) acc_cycle = c + 1;
      step();
      if (acc) wordValid = 1'b0;
    end
    chk("b2b_gap", 32'(acc_cycle), 32'(b2b_gap));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_bus_writer.md
# word_bus_writer

Drives a 16-bit word onto the 8-bit data bus as two sequential byte transfers, generating the `setHigh`/`setLow` strobe pair that a two-phase 16-bit register load consumes. It is the transmit side of the split-word load path. The CPU datapath hands it a full word through a valid/ready handshake, and it walks the word out one half at a time, stalling on bus back-pressure.

## Interface
- `HIGH_FIRST`, default 1: 1 sends the top byte first; 0 sends the bottom byte first.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `wordIn`  in  16  word to transmit; sampled only on the accept edge.
- `wordValid`  in  1  upstream offers `wordIn`.
- `wordReady`  out  1  block can accept a word this cycle.
- `busReady`  in  1  downstream takes the presented byte at this edge.
- `halfValueOut`  out  8  byte on the data bus.
- `setHighOut`  out  1  `halfValueOut` is `word[15:8]`.
- `setLowOut`  out  1  `halfValueOut` is `word[7:0]`.
- `busy`  out  1  a word is in flight (state not IDLE).
- `wordDone`  out  1  one-cycle pulse after the second byte is taken.

## Operation
- FSM states:
  - IDLE
  - SEND_FIRST
  - SEND_SECOND
- Word accept: happens when `wordValid && wordReady` at an edge. The word latches into an internal 16-bit register, and the FSM moves IDLE→SEND_FIRST.
- SEND_FIRST:
  - With `HIGH_FIRST`=1, drive `setHighOut`=1 and `halfValueOut`=`word[15:8]`; otherwise drive the low strobe with the low byte.
  - Hold here while `busReady`=0.
  - On an edge with `busReady`=1, go to SEND_SECOND.
- SEND_SECOND:
  - Drive the other strobe with the other byte.
  - On `busReady`=1, go to IDLE and set `wordDone` for the next cycle.
- Output rules:
  - `setHighOut` and `setLowOut` are never both 1.
  - `halfValueOut` is 8'h00 whenever neither strobe is high.
  - All outputs come from registers; nothing is combinational from inputs.
- `wordReady` is 1 only in IDLE (base build). `wordValid` arriving while busy is ignored, and upstream must hold it.
- `wordIn` changes after the accept edge have no effect on the word in flight.
- Reset:
  - Reset values:
    - state=IDLE
    - `halfValueOut`=0
    - `setHighOut`=0
    - `setLowOut`=0
    - `busy`=0
    - `wordDone`=0
    - `wordReady`=1 from the first cycle after reset deasserts; 0 while reset is high
  - Reset mid-transfer abandons the word silently: no `wordDone`, and no further strobes.
- Reset and `wordValid` in the same cycle: reset wins and no word is accepted.

## Timing
- Accept at edge N. The first byte is valid in cycle N+1, and the second byte is valid in the cycle after the first byte's `busReady` edge.
- With `busReady` tied high:
  - First byte in N+1, second byte in N+2.
  - `wordDone`=1 and `wordReady`=1 in N+3.
  - Throughput is one word per 3 cycles.
- Each stall cycle (`busReady`=0) extends the current byte by exactly one cycle. Data and strobe stay stable across stalls.
- `busReady` is ignored in IDLE.

## Configuration
- `WORD_BUS_WRITER_SKID_EN` defined: adds a one-entry holding slot.
  - `wordReady` = slot empty, so a word can be accepted while busy.
  - When the second byte is taken with the slot full, the FSM goes directly to SEND_FIRST with the held word. There is no IDLE cycle, and `wordDone` still pulses.
  - Throughput is one word per 2 cycles with `busReady` high.
  - Reset empties the slot.
- Undefined: no slot. Behaviour is exactly as described in Operation.

## Structure
- Package `word_bus_pkg` holds:
  - the state typedef (IDLE/SEND_FIRST/SEND_SECOND)
  - `BYTE_W`=8
  - `WORD_W`=16
- Sub-module `word_hold_slot` is the skid slot, instantiated only under `WORD_BUS_WRITER_SKID_EN`. Its ports are `clock`, `reset`, load, unload, data, and full.

## Test plan
- Reset then a single word: `wordIn`=16'hA55A, `busReady`=1, HIGH_FIRST=1.
  - Required: setHigh/8'hA5 in N+1, then setLow/8'h5A in N+2, then `wordDone` in N+3.
  - Cross-check: a paired 16-bit receiver reads 16'hA55A.
- Back-pressure: `wordIn`=16'h1234, `busReady` low for 2 cycles on each byte.
  - Required: 8'h12 held 3 cycles, then 8'h34 held 3 cycles, with no glitch on the strobes.
- HIGH_FIRST=0 with 16'hBEEF: required order is setLow/8'hEF, then setHigh/8'hBE.
- Reset asserted in SEND_SECOND: required outputs all 0 on the next cycle, no `wordDone`, and `wordReady`=1 after release.
- Words 16'h0001 and 16'hFFFF offered back-to-back with `busReady`=1:
  - Base build: second accept 3 cycles after the first.
  - SKID_EN: bytes 00,01,FF,FF on four consecutive cycles.
